keypad_scanner: RTL and testbench

//  Parametrised row/column matrix keypad scanner with synchroniser, per-frame debounce,

---
 rtl/keypad_scanner.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Row/column matrix keypad scanner. Rows are strobed low one at a time and
// the columns are sensed through a 2-flop synchroniser. One sample of every
// row makes a frame snapshot. At the end of each frame the snapshot is
// classified (no key / one key / several keys) and debounced across frames.
// Accepted changes update key_code/multi and push press/release events into
// a small show-ahead FIFO with a valid/ready handshake.
//
// Parameters
//   ROWS, COLS  matrix size (rows driven, columns sensed)
//   SCAN_DIV    clk cycles spent on each row
//   SETTLE      cycle inside a row slot at which columns are sampled
//   DEBOUNCE    identical consecutive frames needed to accept a change
//   EVT_DEPTH   event FIFO depth (power of 2)
//   KEY_W       key code width
//
// Ports
//   clk           scan clock
//   reset         asynchronous active-high reset
//   row_drive_n   registered row strobes, active low
//   col_sense_n   raw column inputs, asynchronous, active low
//   key_code      debounced key, 0 = none, else 1 + row*COLS + col
//   multi         debounced "more than one contact closed"
//   evt_valid     event FIFO not empty
//   evt_ready     consumer accepts the head event
//   evt_code      head event key code
//   evt_press     head event type, 1 = press, 0 = release
//   evt_overflow  one-cycle pulse when an event is dropped on a full FIFO
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int ROWS      = 4,
  parameter int COLS      = 3,
  parameter int SCAN_DIV  = 1024,
  parameter int SETTLE    = 1008,
  parameter int DEBOUNCE  = 3,
  parameter int EVT_DEPTH = 4,
  parameter int KEY_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  output logic [ROWS-1:0]  row_drive_n,
  input  logic [COLS-1:0]  col_sense_n,
  output logic [KEY_W-1:0] key_code,
  output logic             multi,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KEY_W-1:0] evt_code,
  output logic             evt_press,
  output logic             evt_overflow
);

  localparam int NKEYS = ROWS * COLS;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ST_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int AW    = $clog2(EVT_DEPTH);
  localparam int CW    = AW + 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_SETTLE = DIV_W'(SETTLE);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [ST_W-1:0]  ST_ACCEPT  = ST_W'(DEBOUNCE - 1);
  localparam logic [CW-1:0]    FIFO_FULL  = CW'(EVT_DEPTH);

  // Frame classification
  localparam logic [1:0] CAND_NONE  = 2'd0;
  localparam logic [1:0] CAND_KEY   = 2'd1;
  localparam logic [1:0] CAND_MULTI = 2'd2;

  // Synchroniser
  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;

  // Scan timing
  logic [DIV_W-1:0] div;
  logic [ROW_W-1:0] row;
  logic [ROWS-1:0]  row_sel_n;
  logic             frame_end;

  // Frame snapshot, one bit per contact, index row*COLS + col
  logic [NKEYS-1:0] snapshot;
  logic [NKEYS-1:0] snap_next;

  // Classification of the completed frame
  logic [1:0]       cand_kind;
  logic [KEY_W-1:0] cand_code;
  logic             hit;

  // Debounce state
  logic [1:0]       prev_kind;
  logic [KEY_W-1:0] prev_code;
  logic [ST_W-1:0]  stable;
  logic [ST_W-1:0]  stable_next;
  logic             same;
  logic             accept;

  // Acceptance results
  logic [KEY_W-1:0] key_next;
  logic             multi_next;
  logic             fe_push;
  logic             fe_press;
  logic [KEY_W-1:0] fe_code;
  logic             pend_set;
  logic             pend_valid;
  logic [KEY_W-1:0] pend_code;

  // Event FIFO
  logic             push;
  logic             push_press;
  logic [KEY_W-1:0] push_code;
  logic [KEY_W:0]   mem [EVT_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [KEY_W:0]   head;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  // Column inputs are asynchronous; nothing downstream sees the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_sense_n;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      row <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    row_sel_n = '1;
    for (int i = 0; i < ROWS; i++) begin
      if (row == ROW_W'(i)) row_sel_n[i] = 1'b0;
    end
  end

  // The strobe is registered from the current row, so it trails the row
  // counter by one cycle; row 0 goes low on the first clock after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) row_drive_n <= '1;
    else       row_drive_n <= row_sel_n;
  end

  assign frame_end = (div == DIV_LAST) && (row == ROW_LAST);

  // The sample write is bypassed into snap_next so that classification on
  // the frame-end cycle also works when SETTLE is the last slot cycle.
  always_comb begin
    snap_next = snapshot;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((div == DIV_SETTLE) && (row == ROW_W'(r)))
          snap_next[r*COLS + c] = ~col_sync[c];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) snapshot <= '0;
    else       snapshot <= snap_next;
  end

  always_comb begin
    cand_kind = CAND_NONE;
    cand_code = '0;
    hit       = 1'b0;
    for (int i = 0; i < NKEYS; i++) begin
      if (snap_next[i]) begin
        if (hit) begin
          cand_kind = CAND_MULTI;
        end else begin
          cand_kind = CAND_KEY;
          cand_code = KEY_W'(i + 1);
        end
        hit = 1'b1;
      end
    end
    if (cand_kind == CAND_MULTI) cand_code = '0;
  end

  // stable counts repeats of the same candidate and saturates at the
  // acceptance value, so a held candidate is re-accepted every frame
  // (harmless: re-accepting the current state changes nothing).
  assign same        = (cand_kind == prev_kind) && (cand_code == prev_code);
  assign stable_next = !same ? '0 :
                       (stable == ST_ACCEPT) ? stable : stable + ST_W'(1);
  assign accept      = frame_end && (stable_next == ST_ACCEPT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_kind <= CAND_NONE;
      prev_code <= '0;
      stable    <= '0;
    end else if (frame_end) begin
      prev_kind <= cand_kind;
      prev_code <= cand_code;
      stable    <= stable_next;
    end
  end

  // A direct key-to-key change emits release(old) now and press(new) on the
  // following cycle through the pending slot.
  always_comb begin
    key_next   = key_code;
    multi_next = multi;
    fe_push    = 1'b0;
    fe_press   = 1'b0;
    fe_code    = key_code;
    pend_set   = 1'b0;
    if (accept) begin
      case (cand_kind)
        CAND_NONE: begin
          multi_next = 1'b0;
          if (key_code != '0) begin
            key_next = '0;
            fe_push  = 1'b1;
          end
        end
        CAND_KEY: begin
          multi_next = 1'b0;
          if (cand_code != key_code) begin
            key_next = cand_code;
            fe_push  = 1'b1;
            if (key_code == '0) begin
              fe_press = 1'b1;
              fe_code  = cand_code;
            end else begin
              pend_set = 1'b1;
            end
          end
        end
        default: begin
          multi_next = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code   <= '0;
      multi      <= 1'b0;
      pend_valid <= 1'b0;
      pend_code  <= '0;
    end else begin
      key_code   <= key_next;
      multi      <= multi_next;
      pend_valid <= pend_set;
      if (pend_set) pend_code <= cand_code;
    end
  end

  // Frame ends are many cycles apart, so the pending press never collides
  // with a frame-end push.
  assign push       = fe_push | pend_valid;
  assign push_code  = pend_valid ? pend_code : fe_code;
  assign push_press = pend_valid | fe_press;

  assign evt_valid = (count != '0);
  assign full      = (count == FIFO_FULL);
  assign pop       = evt_valid && evt_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < EVT_DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {push_press, push_code};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
      evt_overflow <= drop;
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_code  = evt_valid ? head[KEY_W-1:0] : '0;
  assign evt_press = evt_valid & head[KEY_W];

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner with a fast scan (8 clk per row,
// 32 clk per frame). A matrix model closes contacts under the strobed rows.
// Key sets change only at frame boundaries, and a frame-level reference
// model decides what the scanner must report: debounce is "the last
// DEBOUNCE frame classifications are identical", and expected events are
// kept in a queue compared in order against events popped from the DUT.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int ROWS      = 4;
  localparam int COLS      = 3;
  localparam int SCAN_DIV  = 8;
  localparam int SETTLE    = 6;
  localparam int DEBOUNCE  = 2;
  localparam int EVT_DEPTH = 4;
  localparam int KEY_W     = 5;
  localparam int NKEYS     = ROWS * COLS;
  localparam int FRAME     = ROWS * SCAN_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ROWS-1:0]  row_drive_n;
  logic [COLS-1:0]  col_sense_n;
  logic [KEY_W-1:0] key_code;
  logic             multi;
  logic             evt_valid;
  logic             evt_ready = 1'b1;
  logic [KEY_W-1:0] evt_code;
  logic             evt_press;
  logic             evt_overflow;

  logic [NKEYS-1:0] pressed = '0;

  typedef struct { int code; int press; int cyc; } obs_t;
  typedef struct { int code; int press; bit pair_second; } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   hist[$];

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   ovf_seen = 0;
  int   exp_ovf = 0;
  int   m_key = 0;
  int   m_multi = 0;
  int   ready_mode = 0;
  bit   block_mode = 0;
  int   block_count = 0;
  bit   strict_timing = 0;
  int   last_obs_cyc = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .SETTLE(SETTLE),
    .DEBOUNCE(DEBOUNCE), .EVT_DEPTH(EVT_DEPTH), .KEY_W(KEY_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_drive_n(row_drive_n),
    .col_sense_n(col_sense_n),
    .key_code(key_code),
    .multi(multi),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code(evt_code),
    .evt_press(evt_press),
    .evt_overflow(evt_overflow)
  );

  // Passive matrix: a closed contact pulls its column low while its row is driven.
  always_comb begin
    col_sense_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row_drive_n[r] && pressed[r*COLS + c]) col_sense_n[c] = 1'b0;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Consumer ready changes just after the rising edge so it is stable at the
  // falling-edge monitor and at the next rising edge.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      evt_ready = 1'b1;
    else if (ready_mode == 1) evt_ready = 1'b0;
    else                      evt_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    obs_t o;
    if (!reset) begin
      if (evt_valid && evt_ready) begin
        o.code  = int'(evt_code);
        o.press = int'(evt_press);
        o.cyc   = cycle;
        obs_q.push_back(o);
      end
      if (evt_overflow) ovf_seen++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [NKEYS-1:0] keyBit(input int k);
    logic [NKEYS-1:0] v;
    v = '0;
    v[k-1] = 1'b1;
    return v;
  endfunction

  task automatic modelPush(input int code, input int press, input bit second);
    exp_t e;
    if (block_mode && block_count >= EVT_DEPTH) begin
      exp_ovf++;
    end else begin
      e.code = code;
      e.press = press;
      e.pair_second = second;
      exp_q.push_back(e);
      if (block_mode) block_count++;
    end
  endtask

  // Frame-level reference: classify the key set, accept when the last
  // DEBOUNCE classifications agree, then apply the acceptance rules.
  task automatic modelFrame(input logic [NKEYS-1:0] keys);
    int  n;
    int  cand;
    bit  agree;
    n = $countones(keys);
    cand = 0;
    if (n > 1) cand = -1;
    else if (n == 1)
      for (int i = 0; i < NKEYS; i++) if (keys[i]) cand = i + 1;
    hist.push_back(cand);
    while (hist.size() > DEBOUNCE) void'(hist.pop_front());
    agree = (hist.size() == DEBOUNCE);
    foreach (hist[i]) if (hist[i] != cand) agree = 0;
    if (agree) begin
      if (cand == 0) begin
        m_multi = 0;
        if (m_key != 0) modelPush(m_key, 0, 0);
        m_key = 0;
      end else if (cand > 0) begin
        m_multi = 0;
        if (cand != m_key) begin
          if (m_key == 0) modelPush(cand, 1, 0);
          else begin
            modelPush(m_key, 0, 0);
            modelPush(cand, 1, 1);
          end
          m_key = cand;
        end
      end else begin
        m_multi = 1;
      end
    end
  endtask

  task automatic modelReset();
    m_key = 0;
    m_multi = 0;
    hist.delete();
    hist.push_back(0);
    exp_q.delete();
    obs_q.delete();
    block_mode = 0;
    block_count = 0;
  endtask

  task automatic compareEvents();
    obs_t o;
    exp_t e;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checkOutput("evt_code", o.code, e.code);
      checkOutput("evt_press", o.press, e.press);
      if (strict_timing && e.pair_second)
        checkOutput("evt_pair_gap", o.cyc - last_obs_cyc, 1);
      last_obs_cyc = o.cyc;
    end
    if (obs_q.size() > 0) begin
      checkOutput("evt_unexpected", obs_q.size(), 0);
      obs_q.delete();
    end
  endtask

  // One frame: set the key set at the frame boundary, run 32 clocks, then
  // check the debounced outputs right after the frame-end update.
  task automatic applyStimulus(input logic [NKEYS-1:0] keys, input bit check_rows);
    logic [ROWS-1:0] exp_rows;
    pressed = keys;
    modelFrame(keys);
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (check_rows) begin
        exp_rows = '1;
        exp_rows[(i-1)/SCAN_DIV] = 1'b0;
        checkOutput("row_drive_n", row_drive_n, exp_rows);
      end
    end
    checkOutput("key_code", key_code, m_key);
    checkOutput("multi", multi, m_multi);
    compareEvents();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rows"}, row_drive_n, 4'b1111);
    checkOutput({tag, "_key"}, key_code, 0);
    checkOutput({tag, "_multi"}, multi, 0);
    checkOutput({tag, "_valid"}, evt_valid, 0);
    checkOutput({tag, "_code"}, evt_code, 0);
    checkOutput({tag, "_press"}, evt_press, 0);
    checkOutput({tag, "_ovf"}, evt_overflow, 0);
  endtask

  initial begin
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] prev_keys;
    int               sel;
    int               k1;
    int               k2;

    // Reset values and the row strobe sequence from a clean release
    modelReset();
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    applyStimulus('0, 1);
    applyStimulus('0, 1);

    // Single key press, hold, release
    strict_timing = 1;
    applyStimulus(keyBit(8), 0);
    applyStimulus(keyBit(8), 0);
    applyStimulus('0, 0);
    applyStimulus('0, 0);

    // Chatter on alternate frames never settles
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? keyBit(1) : '0, 0);

    // Direct key change: release and press on consecutive cycles
    applyStimulus(keyBit(1), 0);
    applyStimulus(keyBit(1), 0);
    applyStimulus(keyBit(8), 0);
    applyStimulus(keyBit(8), 0);
    applyStimulus('0, 0);
    applyStimulus('0, 0);

    // Multiple keys hold the previous code, then release from multi
    applyStimulus(keyBit(2), 0);
    applyStimulus(keyBit(2), 0);
    applyStimulus(keyBit(1) | keyBit(5), 0);
    applyStimulus(keyBit(1) | keyBit(5), 0);
    applyStimulus('0, 0);
    applyStimulus('0, 0);
    applyStimulus('0, 0);

    // Consumer stalled: four events queue, the fifth is dropped
    ready_mode = 1;
    block_mode = 1;
    block_count = 0;
    for (int i = 0; i < 10; i++) begin
      case (i / 2)
        0: keys = keyBit(1);
        2: keys = keyBit(2);
        4: keys = keyBit(3);
        default: keys = '0;
      endcase
      applyStimulus(keys, 0);
    end
    checkOutput("evt_valid_full", evt_valid, 1);
    ready_mode = 0;
    block_mode = 0;
    applyStimulus(keyBit(3), 0);
    applyStimulus(keyBit(3), 0);
    checkOutput("overflow_pulses", ovf_seen, exp_ovf);

    // Reset in the middle of a frame
    repeat (13) @(negedge clk);
    #2;
    reset = 1'b1;
    pressed = '0;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    applyStimulus('0, 1);
    applyStimulus(keyBit(8), 0);
    applyStimulus(keyBit(8), 0);

    // Randomised key activity with a randomly stalling consumer
    strict_timing = 0;
    ready_mode = 2;
    prev_keys = keyBit(8);
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5) keys = prev_keys;
      else if (sel < 7) keys = '0;
      else if (sel < 9) keys = keyBit($urandom_range(1, NKEYS));
      else begin
        k1 = $urandom_range(1, NKEYS);
        k2 = (k1 % NKEYS) + 1;
        keys = keyBit(k1) | keyBit(k2);
      end
      applyStimulus(keys, 0);
      prev_keys = keys;
    end

    // Release everything and drain
    ready_mode = 0;
    applyStimulus('0, 0);
    applyStimulus('0, 0);
    applyStimulus('0, 0);
    checkOutput("evt_missing", exp_q.size(), 0);
    checkOutput("overflow_final", ovf_seen, exp_ovf);
    checkOutput("evt_valid_idle", evt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
